// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the Gamepad Pmod serial link.
// Contents: emitter FSM state encoding, per-controller slice width, button bit
// positions inside a 12-bit controller slice (MSB first on the wire), and the
// all-ones "controller absent" pattern.
package gamepad_pmod_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_LATCH    = 3'd4,
        ST_GAP      = 3'd5
    } pmod_state_e;

    localparam int PAD_BITS = 12;

    // Bit index inside one controller slice; BTN_B is sent first.
    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    localparam logic [PAD_BITS-1:0] PAD_ABSENT = 12'hfff;

    // A slice reading all-ones means no controller is plugged in.
    function automatic logic pad_present(input logic [PAD_BITS-1:0] slice);
        return slice != PAD_ABSENT;
    endfunction

endpackage

// File: rtl/gamepad_pmod_phase_timer.sv
// Loadable down-counter shared by every timed emitter state.
// Ports:
//   clk, rst       : system clock, async active-high reset
//   load, load_val : load (duration - 1) when entering a timed state
//   done           : counter is at zero, i.e. this is the state's last cycle
//   done_next      : done will be high in the next cycle (lets the owner
//                    register pulses that line up with the last cycle)
module gamepad_pmod_phase_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done,
    output logic          done_next
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign done      = (cnt == '0);
    assign done_next = load ? (load_val == '0) : ((cnt == '0) || (cnt == CW'(1)));

endmodule

// File: rtl/gamepad_pmod_emitter.sv
// Transmit side of the Gamepad Pmod link: serialises frame_data MSB first on
// pmod_data/pmod_clk, then pulses pmod_latch, then idles for FRAME_GAP cycles.
// Ports:
//   clk, rst    : system clock, async active-high reset
//   enable      : start / keep free-running frames
//   frame_data  : raw button word, snapshotted at frame start
//   busy        : high from frame start through the end of the gap
//   frame_done  : one-cycle pulse on the last latch cycle
//   pmod_data, pmod_clk, pmod_latch : serial link lines (idle low)
// All outputs are flops fed from the next-state decode, so each line changes
// in the same cycle the FSM enters the corresponding state.
module gamepad_pmod_emitter
    import gamepad_pmod_pkg::*;
#(
    parameter int BIT_WIDTH    = 24,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 2,
    parameter int FRAME_GAP    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] frame_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 pmod_data,
    output logic                 pmod_clk,
    output logic                 pmod_latch
);

    localparam int MAX_DL = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int MAX_C  = (MAX_DL > FRAME_GAP) ? MAX_DL : FRAME_GAP;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int BW_W   = $clog2(BIT_WIDTH + 1);

    // Timer holds (duration - 1); zero marks the last cycle of a state.
    localparam logic [CW-1:0] DIV_LOAD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    pmod_state_e          state, state_nxt;
    logic [BIT_WIDTH-1:0] shift_reg, shift_nxt;
    logic [BW_W-1:0]      bits_left, bits_nxt;
    logic                 tmr_load, tmr_done, tmr_done_next, start;
    logic [CW-1:0]        tmr_val;

    gamepad_pmod_phase_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .done      (tmr_done),
        .done_next (tmr_done_next)
    );

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        bits_nxt  = bits_left;
        tmr_load  = 1'b0;
        tmr_val   = DIV_LOAD;
        start     = 1'b0;
        case (state)
            ST_IDLE: start = enable;
            ST_SHIFT_LO: begin
                if (tmr_done) begin
                    state_nxt = ST_SHIFT_HI;
                    tmr_load  = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                // Falling pmod_clk and the next data bit land together.
                if (tmr_done) begin
                    shift_nxt = {shift_reg[BIT_WIDTH-2:0], 1'b0};
                    bits_nxt  = bits_left - BW_W'(1);
                    state_nxt = (bits_left == BW_W'(1)) ? ST_SETTLE : ST_SHIFT_LO;
                    tmr_load  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_nxt = ST_LATCH;
                    tmr_load  = 1'b1;
                    tmr_val   = LATCH_LOAD;
                end
            end
            ST_LATCH: begin
                if (tmr_done) begin
                    if (FRAME_GAP > 0) begin
                        state_nxt = ST_GAP;
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LOAD;
                    end else if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    if (enable) start = 1'b1;
                    else        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Frame start is shared by IDLE and the back-to-back path out of the gap.
        if (start) begin
            state_nxt = ST_SHIFT_LO;
            shift_nxt = frame_data;
            bits_nxt  = BW_W'(BIT_WIDTH);
            tmr_load  = 1'b1;
            tmr_val   = DIV_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bits_left  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pmod_data  <= 1'b0;
            pmod_clk   <= 1'b0;
            pmod_latch <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bits_left  <= bits_nxt;
            busy       <= (state_nxt != ST_IDLE);
            frame_done <= (state_nxt == ST_LATCH) && tmr_done_next;
            pmod_data  <= ((state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI))
                          && shift_nxt[BIT_WIDTH-1];
            pmod_clk   <= (state_nxt == ST_SHIFT_HI);
            pmod_latch <= (state_nxt == ST_LATCH);
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_emitter.sv
// Scoreboard bench for gamepad_pmod_emitter. A frame-level model records each
// frame start (cycle + snapshotted word) and predicts the line waveforms from
// the frame timing; a monitor compares the lines every cycle and a receiver
// model rebuilds each word on pmod_clk rising edges, checked at the latch.
module tb_gamepad_pmod_emitter;
    import gamepad_pmod_pkg::*;

    localparam int BW        = 24;
    localparam int CD        = 2;
    localparam int LC        = 2;
    localparam int FG        = 4;
    localparam int SHIFT_CYC = 2 * CD * BW;
    localparam int DONE_OFS  = SHIFT_CYC + CD + LC;
    localparam int T         = DONE_OFS + FG;

    logic          clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [BW-1:0] frame_data = '0;
    logic          busy, frame_done, pmod_data, pmod_clk, pmod_latch;

    gamepad_pmod_emitter #(
        .BIT_WIDTH(BW), .CLK_DIV(CD), .LATCH_CYCLES(LC), .FRAME_GAP(FG)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_data(frame_data),
        .busy(busy), .frame_done(frame_done), .pmod_data(pmod_data),
        .pmod_clk(pmod_clk), .pmod_latch(pmod_latch)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, ls = -1000, next_free = 0, n_starts = 0, n_abort = 0;
    logic [BW-1:0] cur_w = '0;
    logic [BW-1:0] exp_q[$];
    int rd_idx = 0, rx_cnt = 0, latches = 0, mo;
    logic [BW-1:0] rx_sh = '0;
    logic prev_clk = 1'b0, prev_latch = 1'b0, end_req = 1'b0, end_ack = 1'b0;
    logic e_busy, e_clk, e_data, e_latch, e_done;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level model: a frame starts on any edge where enable is seen and
    // the previous frame (start + T) has run out; the word is taken there.
    always @(posedge clk) begin
        if (rst) begin
            if (ls > -1000 && cyc - ls <= DONE_OFS) n_abort++;
            ls        = -1000;
            next_free = 0;
        end else if (enable && cyc >= next_free) begin
            ls        = cyc;
            next_free = cyc + T;
            cur_w     = frame_data;
            exp_q.push_back(frame_data);
            n_starts++;
        end
        cyc++;
    end

    // Monitor: per-cycle waveform compare plus receiver / scoreboard.
    always @(negedge clk) begin
        mo      = cyc - ls;
        e_busy  = !rst && mo >= 1 && mo <= T;
        e_clk   = 1'b0;
        e_data  = 1'b0;
        if (!rst && mo >= 1 && mo <= SHIFT_CYC) begin
            e_clk  = (((mo - 1) / CD) % 2) == 1;
            e_data = cur_w[BW - 1 - (mo - 1) / (2 * CD)];
        end
        e_latch = !rst && mo > DONE_OFS - LC && mo <= DONE_OFS;
        e_done  = !rst && mo == DONE_OFS;
        check("busy",       int'(busy),       int'(e_busy));
        check("pmod_clk",   int'(pmod_clk),   int'(e_clk));
        check("pmod_data",  int'(pmod_data),  int'(e_data));
        check("pmod_latch", int'(pmod_latch), int'(e_latch));
        check("frame_done", int'(frame_done), int'(e_done));

        if (rst) begin
            rx_cnt = 0;
            rx_sh  = '0;
            rd_idx = exp_q.size();   // any frame in flight is aborted
            prev_clk   = 1'b0;
            prev_latch = 1'b0;
        end else begin
            if (pmod_clk && !prev_clk) begin
                rx_sh = {rx_sh[BW-2:0], pmod_data};
                rx_cnt++;
            end
            if (pmod_latch && !prev_latch) begin
                latches++;
                check("clk_edges_per_frame", rx_cnt, BW);
                if (rd_idx < exp_q.size()) begin
                    check("rx_word", int'(rx_sh), int'(exp_q[rd_idx]));
                    check("is_present",
                          int'({pad_present(rx_sh[23:12]), pad_present(rx_sh[11:0])}),
                          int'({pad_present(exp_q[rd_idx][23:12]), pad_present(exp_q[rd_idx][11:0])}));
                    rd_idx++;
                end else begin
                    check("unexpected_latch", 1, 0);
                end
                rx_cnt = 0;
            end
            prev_clk   = pmod_clk;
            prev_latch = pmod_latch;
        end

        if (end_req && !end_ack) begin
            check("frames_delivered", latches, n_starts - n_abort);
            check("scoreboard_drained", rd_idx, exp_q.size());
            end_ack = 1'b1;
        end
    end

    task automatic pulse_frame(input logic [BW-1:0] w);
        @(posedge clk); #1 frame_data = w; enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        repeat (T + 5) @(posedge clk);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Reset asserted mid-cycle and held: lines must stay low.
        #2 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;

        // Single frames, including an absent controller 2.
        pulse_frame(24'hA5C3F0);
        pulse_frame(24'hFFF800);

        // Free-run; word changes 5 cycles into frame 1.
        @(posedge clk); #1 frame_data = 24'h13579B; enable = 1'b1;
        repeat (5) @(posedge clk);
        #1 frame_data = 24'hECA864;
        repeat (2 * T) @(posedge clk);
        #1 enable = 1'b0;
        repeat (2 * T) @(posedge clk);

        // Enable drops during SHIFT_HI of bit 3.
        @(posedge clk); #1 frame_data = 24'h5A5A5A; enable = 1'b1;
        repeat (15) @(posedge clk);
        #1 enable = 1'b0;
        repeat (T + 10) @(posedge clk);

        // Random words, hold times and idle spacing.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 frame_data = BW'($urandom()); enable = 1'b1;
            repeat ($urandom_range(1, 2 * T)) begin
                @(posedge clk);
                #1 if ($urandom_range(0, 7) == 0) frame_data = BW'($urandom());
            end
            enable = 1'b0;
            repeat ($urandom_range(0, T + 10)) @(posedge clk);
        end
        repeat (T + 5) @(posedge clk);

        // Reset after bit 10 of a frame: no latch, then a clean frame.
        pulse_frame(24'h000001);
        @(posedge clk); #1 frame_data = 24'h800800; enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        repeat (10 * 2 * CD) @(posedge clk);
        #1 rst = 1'b1; frame_data = 24'h123456; enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (T - 5) @(posedge clk);
        #1 enable = 1'b0;
        repeat (T + 10) @(posedge clk);

        end_req = 1'b1;
        repeat (3) @(posedge clk);
        if (!end_ack) begin
            $display("FAIL end_handshake got=0 want=1");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        end else begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        end
        $finish;
    end

endmodule
